// File: rtl/uart_hex_receiver.sv
// 8N1 UART receiver that assembles ASCII hex digits, MSB-first, into a DIGITS-nibble word.
// Flags a completed word on flag_start, and a framing error or non-hex byte on flag_err.
module uart_hex_receiver #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned DIGITS       = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in,
  output logic [4*DIGITS-1:0]   data,
  output logic                  flag_start,
  output logic                  flag_err,
  output logic                  flag_busy
);

  localparam int unsigned W  = 4 * DIGITS;
  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned DW = $clog2(DIGITS + 1);

  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [DW-1:0] WORD_LAST = DW'(DIGITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic          rx_meta;
  logic          rxs;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic [DW-1:0] count;
  logic [W-1:0]  acc;

  logic          is_hex;
  logic          is_ws;
  logic [3:0]    nib;
  logic [W-1:0]  acc_next;

  // The received byte is fully in 'shift' by the time the stop bit is sampled.
  always_comb begin
    is_hex   = 1'b0;
    is_ws    = 1'b0;
    nib      = '0;
    if (shift >= 8'h30 && shift <= 8'h39) begin
      is_hex = 1'b1;
      nib    = shift[3:0];
    end else if ((shift >= 8'h41 && shift <= 8'h46) ||
                 (shift >= 8'h61 && shift <= 8'h66)) begin
      is_hex = 1'b1;
      nib    = shift[3:0] + 4'd9;
    end else if (shift == 8'h0D || shift == 8'h0A || shift == 8'h20) begin
      is_ws  = 1'b1;
    end
    acc_next = (acc << 4) | W'(nib);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta    <= 1'b1;
      rxs        <= 1'b1;
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      count      <= '0;
      acc        <= '0;
      data       <= '0;
      flag_start <= 1'b0;
      flag_err   <= 1'b0;
    end else begin
      rx_meta    <= in;
      rxs        <= rx_meta;
      flag_start <= 1'b0;
      flag_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (!rxs) begin
            state <= START;
            cnt   <= '0;
          end
        end
        START: begin
          if (cnt == HALF_LAST) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rxs ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == BIT_LAST) begin
            cnt     <= '0;
            shift   <= {rxs, shift[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          // Leave at mid-stop so a frame that follows with no idle gap is still caught.
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            state <= IDLE;
            if (!rxs) begin
              flag_err <= 1'b1;
              count    <= '0;
            end else if (is_hex) begin
              acc <= acc_next;
              if (count == WORD_LAST) begin
                data       <= acc_next;
                flag_start <= 1'b1;
                count      <= '0;
              end else begin
                count <= count + 1'b1;
              end
            end else if (is_ws) begin
              count <= '0;
            end else begin
              flag_err <= 1'b1;
              count    <= '0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign flag_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_hex_receiver.sv
// Bench for uart_hex_receiver: serial frames driven at the bit level, and results checked
// against a byte-level model of the hex-word rules.
module tb_uart_hex_receiver;

  localparam int unsigned C = 16;
  localparam int unsigned D = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx = 1'b1;
  logic [15:0] data;
  logic        flag_start;
  logic        flag_err;
  logic        flag_busy;

  uart_hex_receiver #(.CLKS_PER_BIT(C), .DIGITS(D)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in         (rx),
    .data       (data),
    .flag_start (flag_start),
    .flag_err   (flag_err),
    .flag_busy  (flag_busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  int seen_start = 0;
  int seen_err   = 0;
  int seen_both  = 0;
  int busy_cnt   = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (flag_start) seen_start++;
      if (flag_err) seen_err++;
      if (flag_start && flag_err) seen_both++;
      if (flag_busy) busy_cnt++;
    end
  end

  // Reference model: word assembly at the byte level.
  int          exp_start = 0;
  int          exp_err   = 0;
  int          m_cnt     = 0;
  logic [15:0] m_acc     = '0;
  logic [15:0] exp_data  = '0;

  task automatic model_byte(input logic [7:0] b, input bit stop_ok);
    int v;
    int bi;
    bi = int'(b);
    v  = -1;
    if (!stop_ok) begin
      exp_err++;
      m_cnt = 0;
      return;
    end
    if (bi >= 48 && bi <= 57) v = bi - 48;
    else if (bi >= 65 && bi <= 70) v = bi - 55;
    else if (bi >= 97 && bi <= 102) v = bi - 87;
    if (v >= 0) begin
      m_acc = 16'((int'(m_acc) * 16 + v) % 65536);
      m_cnt++;
      if (m_cnt == D) begin
        exp_data = m_acc;
        exp_start++;
        m_cnt = 0;
      end
    end else if (bi == 13 || bi == 10 || bi == 32) begin
      m_cnt = 0;
    end else begin
      exp_err++;
      m_cnt = 0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok, input int gap);
    @(negedge clk);
    rx = 1'b0;
    repeat (C) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (C) @(negedge clk);
    end
    rx = stop_ok;
    repeat (C) @(negedge clk);
    rx = 1'b1;
    repeat (C * gap) @(negedge clk);
    model_byte(b, stop_ok);
  endtask

  task automatic send_str(input string s, input int gap);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1, gap);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({data, flag_start, flag_err, flag_busy} !== 19'h0) begin
      n_bad++;
      $display("FAIL reset_hold: got data=%h st=%b er=%b busy=%b, expected all 0",
               data, flag_start, flag_err, flag_busy);
    end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    n_cmp++;
    if ({data, flag_start, flag_err, flag_busy} !== 19'h0) begin
      n_bad++;
      $display("FAIL reset_release: got data=%h st=%b er=%b busy=%b, expected all 0",
               data, flag_start, flag_err, flag_busy);
    end
  endtask

  task automatic test_basic;
    int s0;
    int e0;
    s0 = seen_start;
    e0 = seen_err;
    send_str("12AB", 1);
    n_cmp++;
    if (data !== 16'h12AB) begin
      n_bad++;
      $display("FAIL basic_data: got %h, expected 12ab", data);
    end
    n_cmp++;
    if (seen_start - s0 !== 1) begin
      n_bad++;
      $display("FAIL basic_pulses: got %0d, expected 1", seen_start - s0);
    end
    n_cmp++;
    if (seen_err !== e0) begin
      n_bad++;
      $display("FAIL basic_err: got %0d, expected %0d", seen_err, e0);
    end
  endtask

  task automatic test_lowercase;
    int s0;
    s0 = seen_start;
    send_str("beef", 1);
    n_cmp++;
    if (data !== 16'hBEEF) begin
      n_bad++;
      $display("FAIL lower_data: got %h, expected beef", data);
    end
    send_str("0001", 1);
    n_cmp++;
    if (data !== 16'h0001) begin
      n_bad++;
      $display("FAIL lower_data2: got %h, expected 0001", data);
    end
    n_cmp++;
    if (seen_start - s0 !== 2) begin
      n_bad++;
      $display("FAIL lower_pulses: got %0d, expected 2", seen_start - s0);
    end
  endtask

  task automatic test_whitespace;
    int s0;
    int e0;
    s0 = seen_start;
    e0 = seen_err;
    send_str("12", 1);
    send_byte(8'h0D, 1'b1, 1);
    send_str("34AB", 1);
    n_cmp++;
    if (data !== 16'h34AB) begin
      n_bad++;
      $display("FAIL ws_data: got %h, expected 34ab", data);
    end
    n_cmp++;
    if (seen_start - s0 !== 1) begin
      n_bad++;
      $display("FAIL ws_pulses: got %0d, expected 1", seen_start - s0);
    end
    n_cmp++;
    if (seen_err !== e0) begin
      n_bad++;
      $display("FAIL ws_err: got %0d, expected %0d", seen_err, e0);
    end
  endtask

  task automatic test_glitch;
    int b0;
    logic [15:0] d0;
    b0 = busy_cnt;
    d0 = data;
    @(negedge clk);
    rx = 1'b0;
    repeat (C / 4) @(negedge clk);
    rx = 1'b1;
    repeat (2 * C) @(negedge clk);
    n_cmp++;
    if (!(busy_cnt > b0)) begin
      n_bad++;
      $display("FAIL glitch_busy: got busy cycles %0d, expected > 0", busy_cnt - b0);
    end
    n_cmp++;
    if (flag_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL glitch_idle: got busy=%b, expected 0", flag_busy);
    end
    n_cmp++;
    if (data !== d0) begin
      n_bad++;
      $display("FAIL glitch_data: got %h, expected %h", data, d0);
    end
    n_cmp++;
    if (seen_start !== exp_start || seen_err !== exp_err) begin
      n_bad++;
      $display("FAIL glitch_flags: got st=%0d er=%0d, expected st=%0d er=%0d",
               seen_start, seen_err, exp_start, exp_err);
    end
    send_str("C0DE", 1);
    n_cmp++;
    if (data !== 16'hC0DE) begin
      n_bad++;
      $display("FAIL glitch_after: got %h, expected c0de", data);
    end
  endtask

  task automatic test_framing;
    int e0;
    e0 = seen_err;
    send_str("1", 1);
    send_byte(8'h32, 1'b0, 2);
    n_cmp++;
    if (seen_err - e0 !== 1) begin
      n_bad++;
      $display("FAIL frame_err: got %0d, expected 1", seen_err - e0);
    end
    send_str("0C0D", 1);
    n_cmp++;
    if (data !== 16'h0C0D) begin
      n_bad++;
      $display("FAIL frame_data: got %h, expected 0c0d", data);
    end
    send_str("AB", 1);
    send_byte(8'h47, 1'b1, 1);
    n_cmp++;
    if (seen_err - e0 !== 2) begin
      n_bad++;
      $display("FAIL badchar_err: got %0d, expected 2", seen_err - e0);
    end
    send_str("1234", 1);
    n_cmp++;
    if (data !== 16'h1234) begin
      n_bad++;
      $display("FAIL badchar_data: got %h, expected 1234", data);
    end
    n_cmp++;
    if (seen_start !== exp_start || seen_err !== exp_err) begin
      n_bad++;
      $display("FAIL frame_counts: got st=%0d er=%0d, expected st=%0d er=%0d",
               seen_start, seen_err, exp_start, exp_err);
    end
  endtask

  task automatic test_back_to_back;
    send_str("9f3A", 0);
    n_cmp++;
    if (data !== 16'h9F3A) begin
      n_bad++;
      $display("FAIL b2b_data: got %h, expected 9f3a", data);
    end
    send_str("5d7e", 0);
    n_cmp++;
    if (data !== 16'h5D7E) begin
      n_bad++;
      $display("FAIL b2b_data2: got %h, expected 5d7e", data);
    end
    n_cmp++;
    if (seen_start !== exp_start || seen_err !== exp_err) begin
      n_bad++;
      $display("FAIL b2b_counts: got st=%0d er=%0d, expected st=%0d er=%0d",
               seen_start, seen_err, exp_start, exp_err);
    end
  endtask

  task automatic test_random;
    string      hexset;
    logic [7:0] b;
    bit         ok;
    int         gap;
    int         kind;
    hexset = "0123456789ABCDEFabcdef";
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 9);
      ok   = 1'b1;
      gap  = $urandom_range(0, 2);
      if (kind <= 5) b = hexset[$urandom_range(0, 21)];
      else if (kind == 6) b = (($urandom_range(0, 1) == 0) ? 8'h20 : 8'h0A);
      else if (kind == 7) b = 8'($urandom);
      else if (kind == 8) begin
        b   = 8'($urandom);
        ok  = 1'b0;
        gap = 2;
      end else b = hexset[$urandom_range(0, 15)];
      send_byte(b, ok, gap);
      n_cmp++;
      if (data !== exp_data) begin
        n_bad++;
        $display("FAIL rand_data[%0d]: got %h, expected %h", n, data, exp_data);
      end
      n_cmp++;
      if (seen_start !== exp_start) begin
        n_bad++;
        $display("FAIL rand_start[%0d]: got %0d, expected %0d", n, seen_start, exp_start);
      end
      n_cmp++;
      if (seen_err !== exp_err) begin
        n_bad++;
        $display("FAIL rand_err[%0d]: got %0d, expected %0d", n, seen_err, exp_err);
      end
    end
  endtask

  task automatic test_reset_midframe;
    int         s0;
    logic [7:0] b;
    b = 8'h46;
    send_str("FF", 1);
    @(negedge clk);
    rx = 1'b0;
    repeat (C) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx = b[i];
      repeat (C) @(negedge clk);
    end
    n_cmp++;
    if (flag_busy !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_busy: got %b, expected 1", flag_busy);
    end
    #3 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({data, flag_start, flag_err, flag_busy} !== 19'h0) begin
      n_bad++;
      $display("FAIL mid_reset: got data=%h st=%b er=%b busy=%b, expected all 0",
               data, flag_start, flag_err, flag_busy);
    end
    rx = 1'b1;
    m_cnt    = 0;
    m_acc    = '0;
    exp_data = '0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    s0 = seen_start;
    repeat (2 * C) @(negedge clk);
    send_str("A5A5", 1);
    n_cmp++;
    if (data !== 16'hA5A5) begin
      n_bad++;
      $display("FAIL mid_after: got %h, expected a5a5", data);
    end
    n_cmp++;
    if (seen_start - s0 !== 1) begin
      n_bad++;
      $display("FAIL mid_pulses: got %0d, expected 1", seen_start - s0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_lowercase();
    test_whitespace();
    test_glitch();
    test_framing();
    test_back_to_back();
    test_random();
    test_reset_midframe();
    n_cmp++;
    if (seen_both !== 0) begin
      n_bad++;
      $display("FAIL start_err_overlap: got %0d cycles, expected 0", seen_both);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_hex_receiver.md
Name: uart_hex_receiver

Overview:
- Upstream stage of the console transmit path: serial UART receiver plus ASCII-hex word assembler.
- Receives 8N1 frames on `in` and decodes each byte as a hex digit.
- Accumulates DIGITS nibbles MSB-first into `data`, then pulses `flag_start` for one cycle so the downstream queue/transmitter echoes the word.
- Reports framing and non-hex errors on `flag_err`.

Parameters:
- CLKS_PER_BIT, 434: clk cycles per UART bit (50 MHz / 115200); legal range >= 4.
- DIGITS, 4: hex digits per word; `data` width is 4*DIGITS.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in  input  1  UART RX line, idle high, asynchronous to clk
- data  output  4*DIGITS  last completed word, first received digit in the MS nibble
- flag_start  output  1  one-cycle pulse: `data` just updated with a complete word
- flag_err  output  1  one-cycle pulse: framing error or illegal character
- flag_busy  output  1  high while a frame is being received (FSM not IDLE)

Behaviour:
- Reset (rst_n low, asynchronous):
  - data = 0, flag_start = 0, flag_err = 0, flag_busy = 0.
  - FSM to IDLE; digit count, accumulator and bit counters to 0.
  - Synchroniser flops preset to 1.
- Reset asserted mid-frame aborts the frame and the partial word; nothing is emitted.
- `in` passes through a 2-flop synchroniser, rxs. All sampling uses rxs.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: rxs == 0 -> START, clear cycle counter.
  - START: after CLKS_PER_BIT/2 cycles (integer division), sample rxs.
    - 0 -> DATA, bit index 0.
    - 1 -> IDLE (glitch): no flag, no state change to the word.
  - DATA: sample every CLKS_PER_BIT cycles, LSB first, into the shift register. After bit 7 -> STOP.
  - STOP: sample CLKS_PER_BIT cycles after bit 7, then return to IDLE on the next edge. The FSM does not wait for the full stop bit, so back-to-back frames resync.
    - Stop bit 1: byte is valid; process it as below.
    - Stop bit 0: framing error; flag_err pulses, partial word discarded (count = 0), byte ignored.
- Byte processing happens on the stop-sample edge; results are visible the following cycle.
  - '0'-'9' (0x30-0x39), 'A'-'F' (0x41-0x46), 'a'-'f' (0x61-0x66):
    - Map to nibble 0-F; acc = {acc[4*DIGITS-5:0], nibble}; count++.
    - If count reaches DIGITS: data <= new acc, flag_start = 1 for exactly one cycle, count = 0.
  - CR (0x0D), LF (0x0A), space (0x20): silently discard the partial word (count = 0); no flags.
  - Any other byte: flag_err pulse, count = 0.
- `data` holds its value between words; partial digits never appear on `data`.
- flag_start and flag_err are never asserted in the same cycle.
- Line stuck low:
  - Each false START returns to IDLE only if rxs is high at mid-start.
  - Otherwise a 0x00 frame with bad stop produces flag_err, then the FSM re-arms.
- Latency: flag_start rises 1 clk after the stop-bit mid-sample of the last digit, i.e. about 9.5 bit times + 3 clk after that frame's start edge on `in`.

Test Plan:
- Send "12AB" at CLKS_PER_BIT=434, 1-bit idle between frames -> single flag_start pulse after 4th frame, data = 0x12AB, flag_err never high.
- Send "beef" lowercase -> data = 0xBEEF. Then "0001" -> data = 0x0001, two pulses total.
- Send "12", CR, "34AB" -> exactly one flag_start, data = 0x34AB. The CR causes no flag_err.
- Pulse `in` low for 100 cycles (< 217) -> flag_busy high then back to IDLE, no flags, data unchanged. Then a valid word still decodes.
- Send "1", then a frame 0x32 with stop bit forced 0 -> one flag_err pulse. Then "0C0D" -> data = 0x0C0D. Also send 'G' (0x47) -> flag_err, count cleared.
- Assert rst_n low mid-DATA of 3rd digit of "FFFF" -> all outputs 0 immediately. After release, send "A5A5" -> data = 0xA5A5 with one pulse.
